// File: rtl/regfl_reader_if.sv
// Burst-read request and word-stream bundle between a register file consumer and regfl_reader.
// The master drives q_in, start, start_address, length and dout_ready; the slave returns the words and status.
interface regfl_reader_if #(
    parameter int address_width  = 3,
    parameter int register_count = 2**address_width,
    parameter int data_width     = 64
);
    logic [register_count*data_width-1:0] q_in;
    logic                                 start;
    logic [address_width-1:0]             start_address;
    logic [address_width:0]               length;
    logic                                 dout_ready;
    logic [data_width-1:0]                dout;
    logic [address_width-1:0]             dout_addr;
    logic                                 dout_valid;
    logic                                 busy;
    logic                                 done;

    modport master (
        output q_in, start, start_address, length, dout_ready,
        input  dout, dout_addr, dout_valid, busy, done
    );

    modport slave (
        input  q_in, start, start_address, length, dout_ready,
        output dout, dout_addr, dout_valid, busy, done
    );
endinterface

// File: rtl/regfl_reader.sv
// Streams a wrapping range of a flattened register file as one word per cycle; first word valid one cycle after start.
// Backpressure: with dout_ready low the current word and index are held, and q_in is only sampled at issue edges.
module regfl_reader #(
    parameter int address_width  = 3,
    parameter int register_count = 2**address_width,
    parameter int data_width     = 64
) (
    input  logic          clk,
    input  logic          rst,
    regfl_reader_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [address_width:0]   max_len  = (address_width+1)'(register_count);
    localparam logic [address_width-1:0] last_idx = address_width'(register_count - 1);

    state_t                  state;
    logic [address_width:0]  remaining;

    logic [address_width:0]   eff_len;
    logic [address_width-1:0] next_idx;
    logic [data_width-1:0]    start_word;
    logic [data_width-1:0]    next_word;

    always_comb begin
        eff_len    = (bus.length > max_len) ? max_len : bus.length;
        next_idx   = (bus.dout_addr == last_idx) ? '0 : bus.dout_addr + 1'b1;
        start_word = bus.q_in[int'(bus.start_address)*data_width +: data_width];
        next_word  = bus.q_in[int'(next_idx)*data_width +: data_width];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            remaining      <= '0;
            bus.dout       <= '0;
            bus.dout_addr  <= '0;
            bus.dout_valid <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        if (eff_len != '0) begin
                            state          <= READ;
                            remaining      <= eff_len;
                            bus.dout       <= start_word;
                            bus.dout_addr  <= bus.start_address;
                            bus.dout_valid <= 1'b1;
                            bus.busy       <= 1'b1;
                        end else begin
                            // Zero-length burst still reports completion.
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (bus.dout_ready) begin
                        if (remaining > 1) begin
                            remaining     <= remaining - 1'b1;
                            bus.dout      <= next_word;
                            bus.dout_addr <= next_idx;
                        end else begin
                            state          <= DONE;
                            remaining      <= '0;
                            bus.dout_valid <= 1'b0;
                            bus.busy       <= 1'b0;
                            bus.done       <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                end
                default: begin
                    state          <= IDLE;
                    remaining      <= '0;
                    bus.dout_valid <= 1'b0;
                    bus.busy       <= 1'b0;
                    bus.done       <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfl_reader.sv
// Directed checks of regfl_reader with 8 x 64-bit registers holding 64'h11*i.
module tb_regfl_reader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    regfl_reader_if #(.address_width(3), .register_count(8), .data_width(64)) bus();

    regfl_reader #(.address_width(3), .register_count(8), .data_width(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input int idx, input logic [63:0] val);
        check({tag, "_valid"}, 64'(bus.dout_valid), 64'd1);
        check({tag, "_addr"}, 64'(bus.dout_addr), 64'(idx));
        check({tag, "_dout"}, bus.dout, val);
    endtask

    initial begin
        int words;
        int dones;

        bus.start         = 1'b0;
        bus.start_address = '0;
        bus.length        = '0;
        bus.dout_ready    = 1'b0;
        for (int i = 0; i < 8; i++) bus.q_in[i*64 +: 64] = 64'(i) * 64'h11;

        // Reset asserted mid-clock must clear outputs before any edge.
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        check("rst_dout", bus.dout, 64'd0);
        check("rst_addr", 64'(bus.dout_addr), 64'd0);
        check("rst_valid", 64'(bus.dout_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("idle_busy", 64'(bus.busy), 64'd0);
        check("idle_valid", 64'(bus.dout_valid), 64'd0);
        check("idle_done", 64'(bus.done), 64'd0);

        // Basic burst: start 2, length 3.
        bus.start = 1'b1; bus.start_address = 3'd2; bus.length = 4'd3; bus.dout_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        check_word("b1_w0", 2, 64'h22);
        check("b1_busy", 64'(bus.busy), 64'd1);
        tick();
        check_word("b1_w1", 3, 64'h33);
        tick();
        check_word("b1_w2", 4, 64'h44);
        tick();
        check("b1_end_valid", 64'(bus.dout_valid), 64'd0);
        check("b1_end_done", 64'(bus.done), 64'd1);
        check("b1_end_busy", 64'(bus.busy), 64'd0);
        tick();
        check("b1_idle_done", 64'(bus.done), 64'd0);

        // Wrapping burst: start 6, length 4.
        bus.start = 1'b1; bus.start_address = 3'd6; bus.length = 4'd4;
        tick();
        bus.start = 1'b0;
        check_word("wrap_w0", 6, 64'h66);
        tick();
        check_word("wrap_w1", 7, 64'h77);
        tick();
        check_word("wrap_w2", 0, 64'h00);
        tick();
        check_word("wrap_w3", 1, 64'h11);
        tick();
        check("wrap_done", 64'(bus.done), 64'd1);
        tick();

        // Backpressure on word at index 3 while its register changes.
        bus.start = 1'b1; bus.start_address = 3'd2; bus.length = 4'd3;
        tick();
        bus.start = 1'b0;
        check_word("bp_w0", 2, 64'h22);
        tick();
        check_word("bp_w1", 3, 64'h33);
        bus.dout_ready = 1'b0;
        bus.q_in[3*64 +: 64] = 64'hDEAD;
        tick();
        check_word("bp_hold0", 3, 64'h33);
        tick();
        check_word("bp_hold1", 3, 64'h33);
        tick();
        check_word("bp_hold2", 3, 64'h33);
        bus.dout_ready = 1'b1;
        tick();
        check_word("bp_w2", 4, 64'h44);
        tick();
        check("bp_done", 64'(bus.done), 64'd1);
        bus.q_in[3*64 +: 64] = 64'h33;
        tick();

        // Zero-length burst.
        bus.start = 1'b1; bus.start_address = 3'd5; bus.length = 4'd0;
        tick();
        bus.start = 1'b0;
        check("len0_valid", 64'(bus.dout_valid), 64'd0);
        check("len0_done", 64'(bus.done), 64'd1);
        check("len0_busy", 64'(bus.busy), 64'd0);
        tick();
        check("len0_after_done", 64'(bus.done), 64'd0);
        check("len0_after_valid", 64'(bus.dout_valid), 64'd0);

        // Oversized length clamps to all 8 registers.
        bus.start = 1'b1; bus.start_address = 3'd0; bus.length = 4'd15;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_word($sformatf("clamp_w%0d", k), k, 64'(k) * 64'h11);
            tick();
        end
        check("clamp_done", 64'(bus.done), 64'd1);
        check("clamp_valid", 64'(bus.dout_valid), 64'd0);
        tick();

        // Reset during a burst abandons it without a done pulse.
        bus.start = 1'b1; bus.start_address = 3'd0; bus.length = 4'd8;
        tick();
        bus.start = 1'b0;
        check_word("abort_w0", 0, 64'h00);
        tick();
        check_word("abort_w1", 1, 64'h11);
        rst = 1'b1;
        #1;
        check("abort_valid", 64'(bus.dout_valid), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_dout", bus.dout, 64'd0);
        #2;
        rst = 1'b0;
        tick();
        check("abort_no_done0", 64'(bus.done), 64'd0);
        tick();
        check("abort_no_done1", 64'(bus.done), 64'd0);
        check("abort_idle_valid", 64'(bus.dout_valid), 64'd0);

        // Fresh burst; a start held into READ must not restart or extend it.
        bus.start = 1'b1; bus.start_address = 3'd4; bus.length = 4'd3;
        tick();
        check_word("fresh_w0", 4, 64'h44);
        words = 0;
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.dout_valid) words++;
            if (bus.done) dones++;
            if (c == 1) bus.start = 1'b0;
            tick();
        end
        check("fresh_words", 64'(words), 64'd3);
        check("fresh_dones", 64'(dones), 64'd1);
        check("fresh_idle_busy", 64'(bus.busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
